// File: rtl/z88_mem_pkg.sv
// z88_mem_pkg: shared types and constants for the slot-0 memory arbiter
package z88_mem_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LCD = 1'b1;
  localparam int RAM_SEL_BIT = 19;
endpackage

// File: rtl/z88_mem_rr2.sv
// z88_mem_rr2: two-way round-robin picker, lone requester wins, ties go to the port not served last
module z88_mem_rr2
  import z88_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);
  // pick the winner index and flag whether anyone is asking
  always_comb begin
    valid_o = |req_i;
    grant_o = &req_i ? ~last_grant_i : (req_i[PORT_LCD] ? PORT_LCD : PORT_CPU);
  end
endmodule

// File: rtl/z88_mem_arbiter.sv
// z88_mem_arbiter: arbitrates CPU and LCD ports onto the slot-0 ROM/RAM bus and sequences the strobes
module z88_mem_arbiter
  import z88_mem_pkg::*;
#(
  parameter int AW          = RAM_SEL_BIT,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          lcd_req,
  input  logic          lcd_we,
  input  logic [AW:0]   lcd_addr,
  input  logic [7:0]    lcd_wdata,
  output logic          lcd_ack,
  output logic [7:0]    lcd_rdata,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_di,
  input  logic [7:0]    mem_do,
  output logic          ram_ce_n,
  output logic          rom_ce_n,
  output logic          mem_oe_n,
  output logic          mem_we_n
);
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 7) begin : g_bad_wait
    $error("WAIT_CYCLES must lie in 1..7");
  end

  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [AW:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  lcd_rdata_q, lcd_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        lcd_ack_q, lcd_ack_d;
  logic        ram_ce_n_q, ram_ce_n_d;
  logic        rom_ce_n_q, rom_ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        busy_d;
  logic        grant;
  logic        valid;

  z88_mem_rr2 u_rr (
    .req_i        ({lcd_req, cpu_req}),
    .last_grant_i (last_q),
    .grant_o      (grant),
    .valid_o      (valid)
  );

  // next state, command latch, read capture, and next values of every registered pin
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    lcd_rdata_d = lcd_rdata_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = SETUP;
        win_d   = grant;
        last_d  = grant;
        we_d    = grant ? lcd_we : cpu_we;
        addr_d  = grant ? lcd_addr : cpu_addr;
        wdata_d = grant ? lcd_wdata : cpu_wdata;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_INIT;
      end
      STROBE: if (cnt_q == 3'd0) begin
        state_d     = DONE;
        cpu_rdata_d = (!we_q && win_q == PORT_CPU) ? mem_do : cpu_rdata_q;
        lcd_rdata_d = (!we_q && win_q == PORT_LCD) ? mem_do : lcd_rdata_q;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d     = state_d == SETUP || state_d == STROBE;
    ram_ce_n_d = !(busy_d && addr_d[AW]);
    rom_ce_n_d = !(busy_d && !addr_d[AW] && !we_d);
    oe_n_d     = !(state_d == STROBE && !we_d);
    we_n_d     = !(state_d == STROBE && we_d && addr_d[AW]);
    cpu_ack_d  = state_d == DONE && win_d == PORT_CPU;
    lcd_ack_d  = state_d == DONE && win_d == PORT_LCD;
  end

  // state and pin registers; reset parks the bus with every strobe high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      last_q      <= PORT_LCD;
      win_q       <= PORT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      cpu_rdata_q <= 8'h00;
      lcd_rdata_q <= 8'h00;
      cpu_ack_q   <= 1'b0;
      lcd_ack_q   <= 1'b0;
      ram_ce_n_q  <= 1'b1;
      rom_ce_n_q  <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      win_q       <= win_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      lcd_rdata_q <= lcd_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      lcd_ack_q   <= lcd_ack_d;
      ram_ce_n_q  <= ram_ce_n_d;
      rom_ce_n_q  <= rom_ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  assign mem_a     = addr_q[AW-1:0];
  assign mem_di    = wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign lcd_ack   = lcd_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign lcd_rdata = lcd_rdata_q;
  assign ram_ce_n  = ram_ce_n_q;
  assign rom_ce_n  = rom_ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
endmodule

// File: tb/tb_z88_mem_arbiter.sv
// tb_z88_mem_arbiter: directed vectors, corner sequences and randomized traffic against a transaction-level model
module tb_z88_mem_arbiter;
  localparam int W = 2;

  typedef struct {
    logic        port;
    logic [19:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  dov;
    int          ram_n;
    int          rom_n;
    int          oe_n;
    int          we_n;
    int          ack_c;
    logic [7:0]  rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_v = 2'b00;
  logic [1:0]  we_v = 2'b00;
  logic [19:0] addr_v [2] = '{20'h0, 20'h0};
  logic [7:0]  wd_v [2] = '{8'h0, 8'h0};
  logic        cpu_ack, lcd_ack, ram_ce_n, rom_ce_n, mem_oe_n, mem_we_n;
  logic [7:0]  cpu_rdata, lcd_rdata, mem_di, mem_do;
  logic [18:0] mem_a;
  logic        force_en = 1'b0;
  logic [7:0]  force_do = 8'h00;
  logic [7:0]  phys [16];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A;
  endfunction

  always @(posedge clk) if (!ram_ce_n && !mem_we_n) phys[mem_a[3:0]] <= mem_di;

  assign mem_do = force_en ? force_do : !ram_ce_n ? phys[mem_a[3:0]] : !rom_ce_n ? rom_val(mem_a) : 8'hEE;

  z88_mem_arbiter #(.AW(19), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (req_v[0]),
    .cpu_we    (we_v[0]),
    .cpu_addr  (addr_v[0]),
    .cpu_wdata (wd_v[0]),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .lcd_req   (req_v[1]),
    .lcd_we    (we_v[1]),
    .lcd_addr  (addr_v[1]),
    .lcd_wdata (wd_v[1]),
    .lcd_ack   (lcd_ack),
    .lcd_rdata (lcd_rdata),
    .mem_a     (mem_a),
    .mem_di    (mem_di),
    .mem_do    (mem_do),
    .ram_ce_n  (ram_ce_n),
    .rom_ce_n  (rom_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_v = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic new_cmd(input int p);
    we_v[p]   = 1'($urandom % 2);
    addr_v[p] = 20'($urandom);
    wd_v[p]   = 8'($urandom);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int nram = 0, nrom = 0, noe = 0, nwe = 0, ackc = 0, nack = 0, oack = 0, aerr = 0, derr = 0;
    logic [7:0] rd = 8'h00;
    logic [1:0] acks;
    force_do = v.dov;
    force_en = 1'b1;
    we_v[v.port] = v.we;
    addr_v[v.port] = v.addr;
    wd_v[v.port] = v.wd;
    req_v[v.port] = 1'b1;
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge clk);
      #1;
      acks = {lcd_ack, cpu_ack};
      if (!ram_ce_n) nram++;
      if (!rom_ce_n) nrom++;
      if (!mem_oe_n) noe++;
      if (!mem_we_n) nwe++;
      if ((!ram_ce_n || !rom_ce_n) && mem_a !== v.addr[18:0]) aerr++;
      if (!mem_we_n && mem_di !== v.wd) derr++;
      if (acks[v.port]) begin
        nack++;
        ackc = c;
        rd = v.port ? lcd_rdata : cpu_rdata;
        req_v[v.port] = 1'b0;
      end
      if (acks[!v.port]) oack++;
    end
    force_en = 1'b0;
    chk($sformatf("v%0d_ram_ce_cycles", i), nram, v.ram_n);
    chk($sformatf("v%0d_rom_ce_cycles", i), nrom, v.rom_n);
    chk($sformatf("v%0d_oe_cycles", i), noe, v.oe_n);
    chk($sformatf("v%0d_we_cycles", i), nwe, v.we_n);
    chk($sformatf("v%0d_ack_cycle", i), ackc, v.ack_c);
    chk($sformatf("v%0d_ack_count", i), nack, 1);
    chk($sformatf("v%0d_other_ack", i), oack, 0);
    chk($sformatf("v%0d_mem_a_errs", i), aerr, 0);
    chk($sformatf("v%0d_mem_di_errs", i), derr, 0);
    if (!v.we) chk($sformatf("v%0d_rdata", i), rd, v.rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int got, prev, first_c, gap_bad, both, cnt, aerr;
    int order [4];
    logic [7:0] rd;
    logic [7:0] shadow [16];
    logic sv [16];
    logic inflight [2];
    logic last, pp, pchk, w;
    logic [7:0] prd;
    int nxt, pend_e;
    logic [1:0] rq, exp_ack;
    logic [19:0] sa [2];
    logic sw [2];
    logic [7:0] sd [2];

    vecs[0] = '{1'b0, 20'h92345, 1'b0, 8'h00, 8'hA5, 3, 0, 2, 0, 4, 8'hA5};
    vecs[1] = '{1'b1, 20'h80010, 1'b1, 8'h3C, 8'h00, 3, 0, 0, 2, 4, 8'h00};
    vecs[2] = '{1'b0, 20'h00100, 1'b1, 8'h77, 8'h00, 0, 0, 0, 0, 4, 8'h00};
    vecs[3] = '{1'b1, 20'h7FFFF, 1'b0, 8'h00, 8'h5A, 0, 3, 2, 0, 4, 8'h5A};
    vecs[4] = '{1'b0, 20'hFFFFF, 1'b1, 8'hFF, 8'h00, 3, 0, 0, 2, 4, 8'h00};
    vecs[5] = '{1'b1, 20'h00000, 1'b0, 8'h00, 8'hC3, 0, 3, 2, 0, 4, 8'hC3};

    do_reset();
    chk("reset_strobes_acks", {ram_ce_n, rom_ce_n, mem_oe_n, mem_we_n, cpu_ack, lcd_ack}, 6'b111100);
    chk("reset_mem_a", mem_a, 0);
    chk("reset_mem_di", mem_di, 0);
    chk("reset_rdata", {cpu_rdata, lcd_rdata}, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    do_reset();
    addr_v[0] = 20'h00001; we_v[0] = 1'b0;
    addr_v[1] = 20'h00002; we_v[1] = 1'b0;
    req_v = 2'b11;
    got = 0; prev = 0; first_c = 0; gap_bad = 0; both = 0;
    for (int k = 0; k < 4; k++) order[k] = -1;
    for (int c = 1; c <= 40 && got < 4; c++) begin
      @(posedge clk);
      #1;
      if (cpu_ack && lcd_ack) both++;
      if (cpu_ack || lcd_ack) begin
        order[got] = int'(lcd_ack);
        if (got == 0) first_c = c;
        else if (c - prev != W + 3) gap_bad++;
        prev = c;
        got++;
      end
    end
    req_v = 2'b00;
    chk("tie_ack_total", got, 4);
    chk("tie_first_ack_cycle", first_c, W + 2);
    for (int k = 0; k < 4; k++) chk($sformatf("tie_order%0d", k), order[k], k % 2);
    chk("tie_gap_errs", gap_bad, 0);
    chk("tie_both_acks", both, 0);
    repeat (3) @(posedge clk);
    #1;

    addr_v[0] = 20'h80005; we_v[0] = 1'b0; req_v[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_oe_low", mem_oe_n, 0);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_strobe", {ram_ce_n, rom_ce_n, mem_oe_n, mem_we_n, cpu_ack, lcd_ack}, 6'b111100);
    req_v = 2'b00;
    @(posedge clk);
    #1 reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (cpu_ack || lcd_ack) cnt++;
    end
    chk("no_ack_after_reset", cnt, 0);
    req_v = 2'b11;
    got = -1; first_c = 0;
    for (int c = 1; c <= 10 && got < 0; c++) begin
      @(posedge clk);
      #1;
      if (cpu_ack || lcd_ack) begin got = int'(lcd_ack); first_c = c; end
    end
    req_v = 2'b00;
    chk("post_reset_tie_winner", got, 0);
    chk("post_reset_tie_cycle", first_c, W + 2);
    repeat (3) @(posedge clk);
    #1;

    force_do = 8'h69; force_en = 1'b1;
    addr_v[0] = 20'h80077; we_v[0] = 1'b0; wd_v[0] = 8'h11; req_v[0] = 1'b1;
    aerr = 0; cnt = 0; first_c = 0; rd = 8'h00;
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge clk);
      #1;
      if (c <= W + 2 && mem_a !== 19'h00077) aerr++;
      if (!mem_we_n) cnt++;
      if (cpu_ack) begin first_c = c; rd = cpu_rdata; end
      if (c == 2) begin
        addr_v[0] = 20'h81234; we_v[0] = 1'b1; wd_v[0] = 8'hFF; req_v[0] = 1'b0;
      end
    end
    force_en = 1'b0;
    chk("latched_addr_errs", aerr, 0);
    chk("latched_no_write", cnt, 0);
    chk("dropped_req_ack_cycle", first_c, W + 2);
    chk("dropped_req_rdata", rd, 8'h69);

    do_reset();
    for (int k = 0; k < 16; k++) begin shadow[k] = 8'h00; sv[k] = 1'b0; end
    inflight[0] = 1'b0; inflight[1] = 1'b0;
    last = 1'b1; pp = 1'b0; pchk = 1'b0; prd = 8'h00;
    nxt = 0; pend_e = -1;
    for (int e = 0; e < 3000; e++) begin
      rq = req_v;
      for (int p = 0; p < 2; p++) begin sa[p] = addr_v[p]; sw[p] = we_v[p]; sd[p] = wd_v[p]; end
      @(posedge clk);
      if (e >= nxt && rq != 2'b00) begin
        w = (rq == 2'b11) ? !last : rq[1];
        last = w;
        nxt = e + W + 3;
        pend_e = e + W + 1;
        pp = w;
        pchk = 1'b0;
        if (sw[w] && sa[w][19]) begin
          shadow[sa[w][3:0]] = sd[w];
          sv[sa[w][3:0]] = 1'b1;
        end else if (!sw[w]) begin
          pchk = !sa[w][19] || sv[sa[w][3:0]];
          prd = sa[w][19] ? shadow[sa[w][3:0]] : rom_val(sa[w][18:0]);
        end
        inflight[w] = 1'b1;
      end
      #1;
      exp_ack = (e == pend_e) ? (pp ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_ack", {lcd_ack, cpu_ack}, exp_ack);
      if (e == pend_e && pchk) chk("rnd_rdata", pp ? lcd_rdata : cpu_rdata, prd);
      chk("rnd_strobe_excl", {!ram_ce_n && !rom_ce_n, !mem_oe_n && !mem_we_n, !rom_ce_n && !mem_we_n}, 0);
      for (int p = 0; p < 2; p++) begin
        if (e == pend_e && int'(pp) == p) begin
          inflight[p] = 1'b0;
          req_v[p] = 1'($urandom % 2);
          if (req_v[p]) new_cmd(p);
        end else if (req_v[p]) begin
          if (inflight[p] && $urandom % 8 == 0) req_v[p] = 1'b0;
          if ($urandom % 6 == 0) new_cmd(p);
        end else if (!inflight[p] && $urandom % 3 == 0) begin
          new_cmd(p);
          req_v[p] = 1'b1;
        end
      end
    end
    req_v = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/z88_mem_arbiter.md
# z88_mem_arbiter

Two-port controller for the shared slot-0 memory bus (internal ROM and RAM, 19-bit address, 8-bit data). Arbitrates between the CPU path (Blink-translated Z80 accesses) and the LCD refresh fetcher, then sequences each granted access through setup, strobe and completion phases on the external chip-enable, output-enable and write-enable lines. Sits between the Blink glue and the external memory pins, replacing the direct pin assignments at top level.

## Interface
Parameters:
- AW, 19, memory address width per chip
- WAIT_CYCLES, 2, strobe cycles per access, legal range 1..7

Ports:
- clk  in  1  master clock (all state on rising edge)
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW+1  bit AW: 1 = RAM, 0 = ROM; bits AW-1:0 chip address
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid while cpu_ack = 1
- lcd_req, lcd_we, lcd_addr, lcd_wdata, lcd_ack, lcd_rdata: same as cpu_*, LCD port
- mem_a  out  AW  chip address
- mem_di  out  8  write data to RAM
- mem_do  in  8  read data from ROM/RAM (already muxed by chip enables)
- ram_ce_n, rom_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low strobes

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: if any req high, pick a winner, latch its we/addr/wdata, go SETUP. Else stay.
- Arbitration: single pending request wins. Both pending: grant the port not granted last (round-robin). last_grant resets to LCD, so CPU wins the first tie.
- SETUP (1 cycle): mem_a driven, selected CE low, oe_n/we_n high.
- STROBE (WAIT_CYCLES cycles, counter): CE low; read → mem_oe_n low; write → mem_we_n low, mem_di driven. On the last STROBE edge a read captures mem_do into the winner's rdata register.
- DONE (1 cycle): all strobes high, winner's ack = 1, rdata valid. Next state IDLE.
- ROM write (addr bit AW = 0, we = 1): full sequence and ack, but rom_ce_n and mem_we_n stay high (write discarded).
- Ack only to the granted port. The other port's request stays pending, untouched.
- Latched command is immune to requester input changes after grant.
- A requester dropping req mid-access does not abort. The access completes and the ack is still issued.

## Timing
- Req sampled high in IDLE at edge 0 → SETUP cycle 1 → STROBE cycles 2..WAIT_CYCLES+1 → ack high in cycle WAIT_CYCLES+2, then IDLE.
- Throughput: one access per WAIT_CYCLES+3 cycles. Back-to-back grants are separated by one IDLE cycle, during which the acked port can deassert.
- Reset values: ram_ce_n = rom_ce_n = mem_oe_n = mem_we_n = 1; mem_a = 0; mem_di = 0; acks 0; rdata 0; state IDLE; counter 0; last_grant = LCD.
- Reset mid-access: strobes deassert immediately (async), no ack issued, pending access lost. The requester re-issues after reset.
- All outputs are registered; no combinational path from inputs to strobes or acks.

## Structure
- Package z88_mem_pkg: state enum (IDLE/SETUP/STROBE/DONE), port index constants PORT_CPU = 0 and PORT_LCD = 1, and the RAM-select bit position.
- Sub-module z88_mem_rr2: 2-way round-robin picker. Inputs are req[1:0] and last_grant; outputs are a grant index and a valid flag. Purely combinational, instantiated once.
- Counter width 3 bits. Elaborate-time check on 1 ≤ WAIT_CYCLES ≤ 7.

## Test plan
- CPU read of RAM 0x12345 (cpu_addr = 0x92345), WAIT_CYCLES = 2, mem_do = 0xA5 → ram_ce_n low cycles 1–3, mem_oe_n low cycles 2–3, cpu_ack in cycle 4, cpu_rdata = 0xA5.
- LCD write to RAM 0x00010 with 0x3C → mem_we_n low exactly 2 cycles, mem_di = 0x3C, mem_a = 0x00010, lcd_ack one cycle, rom_ce_n never low.
- Both requests rise in the same cycle after reset and are held → grant order CPU, LCD, CPU, LCD; each ack is one cycle; the other port sees no ack.
- CPU write to ROM 0x00100 → cpu_ack after 4 cycles, rom_ce_n and mem_we_n stay high throughout.
- Reset asserted during STROBE of a read → all strobes high in the same cycle, no ack; after release, state IDLE and a first tie goes to CPU.
- Requester changes cpu_addr during STROBE → mem_a holds the latched address until DONE.
